// File: rtl/mavg_multich_filter_if.sv
// Stream, handshake and config bundle for the multi-channel moving-average filter.
// slave = filter side, master = upstream/downstream side.
interface mavg_multich_filter_if #(
  parameter int IN_DATA_WIDTH  = 12,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int NUM_CH         = 2
);
  logic [3:0]                       cfg_log2_n;
  logic                             cfg_mode;
  logic                             s_valid;
  logic                             s_ready;
  logic [NUM_CH*IN_DATA_WIDTH-1:0]  s_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [NUM_CH*OUT_DATA_WIDTH-1:0] m_data;
  logic                             flush_done;

  modport master (
    output cfg_log2_n, cfg_mode, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, flush_done
  );

  modport slave (
    input  cfg_log2_n, cfg_mode, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, flush_done
  );
endinterface

// File: rtl/mavg_multich_filter.sv
// Multi-channel moving-average filter: sliding-window or block/decimate averaging
// of 2^log2_n samples per channel, single output register with valid/ready.
//
// state    | meaning
// ST_RUN   | normal operation, beats accepted when the output slot is free
// ST_FLUSH | one cycle after a config change: state cleared, input stalled, flush_done high
module mavg_multich_filter #(
  parameter int IN_DATA_WIDTH  = 12,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int NUM_CH         = 2,
  parameter int MAX_LOG2_N     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  mavg_multich_filter_if.slave bus
);
  localparam int DEPTH = 1 << MAX_LOG2_N;
  localparam int AW    = IN_DATA_WIDTH + MAX_LOG2_N;
  localparam int PW    = MAX_LOG2_N;
  localparam int FW    = MAX_LOG2_N + 1;
  localparam int LW    = $clog2(MAX_LOG2_N + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t r_state, w_state_next;

  logic [LW-1:0] w_cfg_log2;
  logic [LW-1:0] r_log2;
  logic          r_mode;
  logic          w_cfg_change;
  logic          w_flush_done;
  logic          w_run;

  logic          w_s_ready;
  logic          w_accept;
  logic          w_emit;
  logic          r_m_valid;
  logic [NUM_CH*OUT_DATA_WIDTH-1:0] r_m_data;
  logic [NUM_CH*OUT_DATA_WIDTH-1:0] w_m_data_next;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] r_phase;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] w_fill_next;
  logic [FW-1:0] w_n;
  logic          w_hist_full;
  logic          w_block_last;

  // Requested window exponent saturates at the history depth.
  assign w_cfg_log2   = (bus.cfg_log2_n > 4'(MAX_LOG2_N)) ? LW'(MAX_LOG2_N)
                                                          : bus.cfg_log2_n[LW-1:0];
  assign w_cfg_change = (w_cfg_log2 != r_log2) || (bus.cfg_mode != r_mode);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_RUN;
    w_flush_done = 1'b0;
    w_run        = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (w_cfg_change) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush_done = 1'b1;
        w_run        = 1'b0;
        if (w_cfg_change) w_state_next = ST_FLUSH;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_s_ready    = rst && w_run && (!r_m_valid || bus.m_ready);
  assign w_accept     = bus.s_valid && w_s_ready;

  assign w_n          = FW'(1) << r_log2;
  assign w_rd_ptr     = r_wr_ptr - w_n[PW-1:0];
  assign w_hist_full  = (r_fill >= w_n);
  assign w_fill_next  = w_hist_full ? r_fill : r_fill + FW'(1);
  assign w_block_last = ({1'b0, r_phase} == (w_n - FW'(1)));
  assign w_emit       = r_mode ? w_block_last : (w_fill_next >= w_n);

  // A beat accepted in the same cycle as a config change is still computed
  // with the old config; the flush below discards its effect on the state.
  always_ff @(posedge clk) begin
    if (!rst || w_cfg_change) begin
      r_log2   <= w_cfg_log2;
      r_mode   <= bus.cfg_mode;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_phase  <= '0;
    end else if (w_accept) begin
      if (r_mode) begin
        r_phase <= w_block_last ? '0 : r_phase + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_fill   <= w_fill_next;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic        [IN_DATA_WIDTH-1:0] r_hist [DEPTH];
    logic signed [AW-1:0]            r_acc;
    logic signed [AW-1:0]            w_sum;
    logic signed [IN_DATA_WIDTH-1:0] w_x;
    logic signed [IN_DATA_WIDTH-1:0] w_old;
    logic signed [IN_DATA_WIDTH-1:0] w_avg;

    assign w_x   = bus.s_data[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    // Stale history past the fill level never reaches the sum.
    assign w_old = (!r_mode && w_hist_full) ? r_hist[w_rd_ptr] : '0;
    assign w_sum = r_acc + AW'(w_x) - AW'(w_old);
    assign w_avg = IN_DATA_WIDTH'(w_sum >>> r_log2);

    assign w_m_data_next[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = OUT_DATA_WIDTH'(w_avg);

    always_ff @(posedge clk) begin
      if (!rst || w_cfg_change) r_acc <= '0;
      else if (w_accept)        r_acc <= (r_mode && w_block_last) ? '0 : w_sum;
    end

    always_ff @(posedge clk) begin
      if (w_accept && !r_mode) r_hist[r_wr_ptr] <= w_x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_accept) begin
      r_m_valid <= w_emit;
      if (w_emit) r_m_data <= w_m_data_next;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  assign bus.flush_done = w_flush_done;

endmodule

// File: tb/tb_mavg_multich_filter.sv
// Bench for mavg_multich_filter: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_mavg_multich_filter;
  localparam int IW = 12;
  localparam int OW = 16;
  localparam int NC = 2;
  localparam int ML = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mavg_multich_filter_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .NUM_CH(NC)) bus ();

  mavg_multich_filter #(
    .IN_DATA_WIDTH (IW),
    .OUT_DATA_WIDTH(OW),
    .NUM_CH        (NC),
    .MAX_LOG2_N    (ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  bit          chk_en    = 1'b0;
  bit          mdl_mode  = 1'b0;
  int          mdl_l     = 0;
  bit          flush_now = 1'b0;
  int          flush_cnt = 0;
  int          win0[$];
  int          win1[$];
  logic [31:0] exp_q[$];
  logic [15:0] cap0[$];
  logic [15:0] cap1[$];

  function automatic int clampl(input logic [3:0] v);
    return (v > 4'(ML)) ? ML : int'(v);
  endfunction

  function automatic int sx(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [15:0] capv(input bit ch, input int i);
    if (ch == 1'b0) return (cap0.size() > i) ? cap0[i] : 16'hDEAD;
    else            return (cap1.size() > i) ? cap1[i] : 16'hDEAD;
  endfunction

  // Reference: keep the samples of the current window, average when it holds N.
  task automatic model_accept(input int x0, input int x1);
    int n;
    int s0;
    int s1;
    n  = 1 << mdl_l;
    s0 = 0;
    s1 = 0;
    win0.push_back(x0);
    win1.push_back(x1);
    if (!mdl_mode && win0.size() > n) begin
      void'(win0.pop_front());
      void'(win1.pop_front());
    end
    if (win0.size() == n) begin
      foreach (win0[i]) s0 += win0[i];
      foreach (win1[i]) s1 += win1[i];
      exp_q.push_back({16'(s1 >>> mdl_l), 16'(s0 >>> mdl_l)});
      if (mdl_mode) begin
        win0.delete();
        win1.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    bit exp_mv;
    bit exp_sr;
    if (chk_en) begin
      exp_mv = (exp_q.size() != 0);
      exp_sr = rst && !flush_now && (!exp_mv || bus.m_ready);
      chk("m_valid", bus.m_valid, exp_mv);
      chk("s_ready", bus.s_ready, exp_sr);
      chk("flush_done", bus.flush_done, flush_now);
      if (exp_mv) chk("m_data", bus.m_data, exp_q[0]);
      if (bus.flush_done === 1'b1) flush_cnt++;
      if (bus.m_valid === 1'b1 && bus.m_ready) begin
        cap0.push_back(bus.m_data[15:0]);
        cap1.push_back(bus.m_data[31:16]);
      end
      if (!rst) begin
        exp_q.delete();
        win0.delete();
        win1.delete();
        mdl_mode  = bus.cfg_mode;
        mdl_l     = clampl(bus.cfg_log2_n);
        flush_now = 1'b0;
      end else begin
        if (exp_mv && bus.m_ready) void'(exp_q.pop_front());
        if (bus.s_valid && exp_sr) model_accept(sx(bus.s_data[11:0]), sx(bus.s_data[23:12]));
        if (bus.cfg_mode != mdl_mode || clampl(bus.cfg_log2_n) != mdl_l) begin
          win0.delete();
          win1.delete();
          mdl_mode  = bus.cfg_mode;
          mdl_l     = clampl(bus.cfg_log2_n);
          flush_now = 1'b1;
        end else begin
          flush_now = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 100), 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send(input int c0, input int c1);
    bus.s_data  = {12'(c1), 12'(c0)};
    bus.s_valid = 1'b1;
    wait_accept();
  endtask

  task automatic set_cfg(input bit m, input logic [3:0] l);
    bus.cfg_mode   = m;
    bus.cfg_log2_n = l;
    idle(3);
  endtask

  task automatic clear_cap();
    cap0.delete();
    cap1.delete();
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bus.cfg_mode   = 1'b0;
    bus.cfg_log2_n = 4'd0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.m_ready    = 1'b1;
    rst            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_data", bus.m_data, 0);
    chk("reset_flush_done", bus.flush_done, 0);
    chk("reset_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // pass-through, 1-cycle latency
    clear_cap();
    send(100, 1);
    @(negedge clk);
    chk("pt_latency", bus.m_valid, 1);
    @(posedge clk);
    #1;
    send(-5, 2);
    send(2047, -2048);
    idle(2);
    chk("pt_count", cap0.size(), 3);
    chk("pt_0", capv(0, 0), 16'd100);
    chk("pt_1", capv(0, 1), 16'hFFFB);
    chk("pt_2", capv(0, 2), 16'd2047);
    chk("pt_ch1_2", capv(1, 2), 16'hF800);

    // beat and config change together: beat uses old config, then flush
    clear_cap();
    f0 = flush_cnt;
    bus.cfg_log2_n = 4'd2;
    send(55, 0);
    idle(3);
    chk("simul_out", capv(0, 0), 16'd55);
    chk("simul_flush", flush_cnt - f0, 1);

    // sliding, N=4
    clear_cap();
    send(4, -8);
    send(8, -8);
    send(12, -8);
    chk("slide_warmup", cap0.size(), 0);
    send(16, -8);
    send(20, -8);
    idle(2);
    chk("slide_count", cap0.size(), 2);
    chk("slide_0", capv(0, 0), 16'd10);
    chk("slide_1", capv(0, 1), 16'd14);
    chk("slide_ch1", capv(1, 1), 16'hFFF8);

    // sliding config change 2 -> 3
    f0 = flush_cnt;
    bus.cfg_log2_n = 4'd3;
    @(negedge clk);
    @(negedge clk);
    chk("cfg_flush_pulse", bus.flush_done, 1);
    chk("cfg_s_ready_low", bus.s_ready, 0);
    @(posedge clk);
    #1;
    clear_cap();
    for (int i = 1; i <= 7; i++) send(i, 0);
    chk("cfg_warmup", cap0.size(), 0);
    send(8, 0);
    idle(2);
    chk("cfg_first_out", capv(0, 0), 16'd4);
    chk("cfg_flush_count", flush_cnt - f0, 1);

    // backpressure
    clear_cap();
    bus.m_ready = 1'b0;
    send(80, 0);
    bus.s_data  = {12'(0), 12'(16)};
    bus.s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_hold", bus.m_data[15:0], 16'd14);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    wait_accept();
    idle(2);
    chk("bp_count", cap0.size(), 2);
    chk("bp_1", capv(0, 1), 16'd16);

    // block, N=8
    set_cfg(1'b1, 4'd3);
    clear_cap();
    for (int i = 0; i < 8; i++) send(7, 3);
    for (int i = 0; i < 8; i++) send(-1, -4);
    idle(2);
    chk("blk_count", cap0.size(), 2);
    chk("blk_0", capv(0, 0), 16'd7);
    chk("blk_1", capv(0, 1), 16'hFFFF);
    chk("blk_ch1_1", capv(1, 1), 16'hFFFC);

    // floor rounding
    set_cfg(1'b1, 4'd1);
    clear_cap();
    send(-3, 5);
    send(0, 0);
    idle(2);
    chk("round_ch0", capv(0, 0), 16'hFFFE);
    chk("round_ch1", capv(1, 0), 16'd2);

    // clamp to N=32, block
    set_cfg(1'b1, 4'd15);
    clear_cap();
    for (int i = 0; i < 32; i++) send(3, -2047);
    idle(2);
    chk("clamp_count", cap0.size(), 1);
    chk("clamp_ch0", capv(0, 0), 16'd3);
    chk("clamp_ch1", capv(1, 0), 16'hF801);
    f0 = flush_cnt;
    set_cfg(1'b1, 4'd7);
    chk("clamp_no_flush", flush_cnt - f0, 0);

    // sliding at full history depth
    set_cfg(1'b0, 4'd5);
    clear_cap();
    for (int i = 0; i < 33; i++) send(i, 0);
    idle(2);
    chk("deep_count", cap0.size(), 2);
    chk("deep_0", capv(0, 0), 16'd15);
    chk("deep_1", capv(0, 1), 16'd16);

    // reset drops the in-flight beat
    set_cfg(1'b1, 4'd2);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(100, 0);
    rst_pulse();
    bus.m_ready = 1'b1;

    // reset mid-block restarts at phase 0
    clear_cap();
    send(80, 0);
    send(80, 0);
    rst_pulse();
    for (int i = 0; i < 4; i++) send(8, 0);
    idle(2);
    chk("rst_blk_count", cap0.size(), 1);
    chk("rst_blk_val", capv(0, 0), 16'd8);

    idle(3);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mavg_multich_filter.md
Name: mavg_multich_filter

Overview:
- Multi-channel moving-average filter for ADC sample streams; successor to the single-channel accumulate-and-dump averager.
- Two modes:
  - Sliding-window mode: one output per input.
  - Block/decimate mode: one output per N inputs.
- Window N = 2^cfg_log2_n; output is the true average (sum >>> log2_n), not the raw sum.
- Sits between the ADC capture stage and the AXI-Stream packer; valid/ready handshake on both sides.

Parameters:
- IN_DATA_WIDTH, 12, per-channel input sample width, two's complement.
- OUT_DATA_WIDTH, 16, per-channel output width; must be >= IN_DATA_WIDTH.
- NUM_CH, 2, channels processed in lockstep; one beat carries one sample per channel.
- MAX_LOG2_N, 5, largest supported window exponent; history depth = 2^MAX_LOG2_N.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-low reset.
- cfg_log2_n, input, 4, window exponent; values > MAX_LOG2_N are clamped to MAX_LOG2_N.
- cfg_mode, input, 1, 0 = sliding window, 1 = block/decimate.
- s_valid, input, 1, input beat valid.
- s_ready, output, 1, input beat accepted when s_valid && s_ready.
- s_data, input, NUM_CH*IN_DATA_WIDTH, channel k at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
- m_valid, output, 1, output beat valid.
- m_ready, input, 1, downstream ready.
- m_data, output, NUM_CH*OUT_DATA_WIDTH, channel k at bits [k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
- flush_done, output, 1, one-cycle pulse when a config-change flush completes.

Behaviour:
- Reset (rst=0 at posedge):
  - m_valid=0, m_data=0, flush_done=0.
  - All accumulators and fill/phase counters = 0; history write pointer = 0.
  - s_ready=0 while rst=0.
- Handshake:
  - s_ready = !m_valid || m_ready (single output register, no bubble).
  - m_data/m_valid are held stable while m_valid && !m_ready.
  - Accept = s_valid && s_ready; all state advances only on accept.
- Arithmetic:
  - Per-channel accumulator width is IN_DATA_WIDTH+MAX_LOG2_N, signed.
  - Average = acc >>> log2_n (arithmetic shift, rounds toward -inf).
  - Average is sign-extended to OUT_DATA_WIDTH; overflow is impossible by construction.
- log2_n = 0 (either mode): pass-through. m_data = sign-extended s_data, m_valid one cycle after accept.
- Sliding mode (cfg_mode=0), N = 2^log2_n:
  - Per-channel circular history of depth 2^MAX_LOG2_N.
  - On accept: acc_next = acc + x - (fill >= N ? hist[wr_ptr-N] : 0); write x at wr_ptr; wr_ptr++ (wraps mod depth).
  - fill saturates at N.
  - Warm-up: the first N-1 accepted beats produce no output.
  - From the N-th accepted beat onward, every accept produces m_valid=1 the next cycle with m_data = acc_next >>> log2_n.
  - Latency: 1 cycle accept -> m_valid.
- Block mode (cfg_mode=1):
  - phase counter 0..N-1.
  - On accept with phase < N-1: acc += x, phase++, no output.
  - On accept with phase = N-1: output (acc + x) >>> log2_n the next cycle, acc = 0, phase = 0.
  - Output rate = input rate / N.
- Config change (cfg_mode or clamped cfg_log2_n differs from the registered copy), sampled every cycle:
  - Next cycle: acc, fill, phase, wr_ptr cleared; registered config updated; flush_done pulses for 1 cycle; s_ready forced 0 for that cycle.
  - A pending m_valid beat is NOT discarded; it still completes its handshake.
  - The history RAM is not cleared; stale entries are masked by fill.
- Simultaneous accept and config change in the same cycle: the beat is processed under the old config; the flush happens the following cycle.
- Reset mid-operation: all state is lost; an output beat that is in flight is dropped (m_valid=0).
- Channels never interact; each channel's arithmetic is identical and independent.

Test Plan:
- Pass-through: log2_n=0, ch0 = 100, -5, 2047 -> m_data ch0 = 100, -5, 2047 sign-extended (16'hFFFB for -5), 1-cycle latency.
- Sliding: log2_n=2, ch0 ramp 4, 8, 12, 16, 20 -> no output for the first 3 beats, then outputs 10, 14; ch1 const -8 -> -8 once warm.
- Block: log2_n=3, ch0 = eight samples of 7 then eight of -1 -> exactly 2 outputs: 7, -1; m_valid never asserted on the other 14 beats.
- Rounding: block mode, log2_n=1, samples -3, 0 -> sum -3, output -2 (floor).
- Backpressure: m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0, m_data held constant; release -> no beat lost or duplicated against the reference model.
- Config change: switch log2_n 2->3 mid-stream in sliding mode -> flush_done pulse, s_ready low 1 cycle, 7-beat warm-up before the next output. Reset pulse mid-block -> m_valid=0 and the next block starts at phase 0.
